// File: rtl/codec_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : codec_seq_pkg
// Brief    : Shared types and constants for the codec sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package codec_seq_pkg;

   localparam int                SAMPLE_W   = 16;
   localparam int                GAIN_W     = 9;
   localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(256);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_LOCK = 3'd1,
      MUTE      = 3'd2,
      RAMP      = 3'd3,
      RUN       = 3'd4
   } state_e;

   // States in which nothing but silence may reach the codec.
   function automatic logic outputs_muted(state_e s);
      return (s == IDLE) || (s == WAIT_LOCK) || (s == MUTE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/codec_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : codec_seq_ctrl_if
// Brief    : Control, codec-link and sample bundle of the sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
interface codec_seq_ctrl_if;
   import codec_seq_pkg::*;

   logic                       enable;
   logic                       clr_fault;
   logic                       valid;
   logic signed [SAMPLE_W-1:0] proc_lft;
   logic signed [SAMPLE_W-1:0] proc_rht;
   logic                       intf_rst_n;
   logic signed [SAMPLE_W-1:0] lft_out;
   logic signed [SAMPLE_W-1:0] rht_out;
   logic                       smp_strobe;
   logic [2:0]                 state;
   logic                       fault;
   logic [3:0]                 retry_cnt;

   modport master (
      input  enable, clr_fault, valid, proc_lft, proc_rht,
      output intf_rst_n, lft_out, rht_out, smp_strobe, state, fault, retry_cnt
   );

   modport slave (
      output enable, clr_fault, valid, proc_lft, proc_rht,
      input  intf_rst_n, lft_out, rht_out, smp_strobe, state, fault, retry_cnt
   );

endinterface
`default_nettype wire

// File: rtl/codec_gain_stage.sv
`default_nettype none
// ============================================================================
// Module   : codec_gain_stage
// Brief    : Registered signed 16x9 stereo scaler (x*gain>>>8) with force-zero.
// Revision : 1.0 - initial release
// ============================================================================
module codec_gain_stage
   import codec_seq_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       force_zero_i,
   input  logic [GAIN_W-1:0]          gain_i,
   input  logic signed [SAMPLE_W-1:0] lft_i,
   input  logic signed [SAMPLE_W-1:0] rht_i,
   output logic signed [SAMPLE_W-1:0] lft_o,
   output logic signed [SAMPLE_W-1:0] rht_o
);

   localparam int PROD_W = SAMPLE_W + GAIN_W;
   localparam int FRAC_W = GAIN_W - 1;

   logic signed [PROD_W-1:0]   w_gain_s;
   logic signed [PROD_W-1:0]   w_prod_l;
   logic signed [PROD_W-1:0]   w_prod_r;
   logic signed [SAMPLE_W-1:0] w_lft_scaled;
   logic signed [SAMPLE_W-1:0] w_rht_scaled;
   logic                       w_lft_sign_unused;
   logic                       w_rht_sign_unused;
   logic [FRAC_W-1:0]          w_lft_frac_unused;
   logic [FRAC_W-1:0]          w_rht_frac_unused;
   logic signed [SAMPLE_W-1:0] lft_q;
   logic signed [SAMPLE_W-1:0] rht_q;

   // Gain is unsigned, so it is zero-extended before entering the signed product.
   assign w_gain_s = $signed(PROD_W'(gain_i));
   assign w_prod_l = PROD_W'(lft_i) * w_gain_s;
   assign w_prod_r = PROD_W'(rht_i) * w_gain_s;

   assign {w_lft_sign_unused, w_lft_scaled, w_lft_frac_unused} = w_prod_l;
   assign {w_rht_sign_unused, w_rht_scaled, w_rht_frac_unused} = w_prod_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         lft_q <= '0;
         rht_q <= '0;
      end else if (force_zero_i) begin
         lft_q <= '0;
         rht_q <= '0;
      end else begin
         lft_q <= w_lft_scaled;
         rht_q <= w_rht_scaled;
      end
   end

   assign lft_o = lft_q;
   assign rht_o = rht_q;

endmodule
`default_nettype wire

// File: rtl/codec_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : codec_seq_ctrl
// Brief    : Codec link bring-up, mute/soft-ramp sequencing and frame watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module codec_seq_ctrl
   import codec_seq_pkg::*;
#(
   parameter int RST_HOLD    = 64,
   parameter int WDOG_CYC    = 2048,
   parameter int MUTE_FRAMES = 8,
   parameter int GAIN_STEP   = 4
)(
   input  logic             clk,
   input  logic             rst,
   codec_seq_ctrl_if.master bus
);

   localparam int HOLD_W = $clog2(RST_HOLD + 1);
   localparam int WD_W   = $clog2(WDOG_CYC + 1);
   localparam int FRM_W  = $clog2(MUTE_FRAMES + 1);

   state_e              state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [FRM_W-1:0]    frame_q, frame_d;
   logic [GAIN_W-1:0]   gain_q, gain_d;
   logic                fault_q, fault_d;
   logic [3:0]          retry_q, retry_d;
   logic                strobe_q, strobe_d;
   logic                valid_q;

   logic                w_vrise;
   logic                w_wd_expire;
   logic [GAIN_W-1:0]   w_gain_sum;

   assign w_vrise     = bus.valid & ~valid_q;
   assign w_wd_expire = (state_q != IDLE) && (wd_q == WD_W'(WDOG_CYC - 1)) && !w_vrise;
   assign w_gain_sum  = gain_q + GAIN_W'(GAIN_STEP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         hold_q   <= '0;
         wd_q     <= '0;
         frame_q  <= '0;
         gain_q   <= '0;
         fault_q  <= 1'b0;
         retry_q  <= '0;
         strobe_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         wd_q     <= wd_d;
         frame_q  <= frame_d;
         gain_q   <= gain_d;
         fault_q  <= fault_d;
         retry_q  <= retry_d;
         strobe_q <= strobe_d;
         valid_q  <= bus.valid;
      end
   end

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      wd_d     = (state_q == IDLE || w_vrise) ? '0 : wd_q + WD_W'(1);
      frame_d  = frame_q;
      gain_d   = gain_q;
      fault_d  = bus.clr_fault ? 1'b0 : fault_q;
      retry_d  = retry_q;
      strobe_d = w_vrise && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (!bus.enable) begin
               hold_d = '0;
            end else if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
               state_d = WAIT_LOCK;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         WAIT_LOCK: begin
            if (w_vrise) begin
               state_d = MUTE;
               frame_d = '0;
            end
         end
         MUTE: begin
            if (w_vrise) begin
               if (frame_q == FRM_W'(MUTE_FRAMES - 1)) begin
                  state_d = RAMP;
                  gain_d  = '0;
               end else begin
                  frame_d = frame_q + FRM_W'(1);
               end
            end
         end
         RAMP: begin
            if (w_vrise) begin
               if (w_gain_sum >= GAIN_UNITY) begin
                  gain_d  = GAIN_UNITY;
                  state_d = RUN;
               end else begin
                  gain_d = w_gain_sum;
               end
            end
         end
         RUN:     gain_d  = GAIN_UNITY;
         default: state_d = IDLE;
      endcase

      // A deliberate disable is not a link failure, so it outranks the watchdog.
      if (!bus.enable) begin
         state_d = IDLE;
      end else if (w_wd_expire) begin
         state_d = IDLE;
         fault_d = 1'b1;
         if (retry_q != 4'hF) begin
            retry_d = retry_q + 4'd1;
         end
      end

      if (state_d != state_q) begin
         wd_d = '0;
      end
      if (state_d == IDLE) begin
         gain_d  = '0;
         frame_d = '0;
      end
   end

   // Muting follows the next state so outputs drop together with the state change.
   codec_gain_stage u_gain (
      .clk          (clk),
      .rst          (rst),
      .force_zero_i (outputs_muted(state_d)),
      .gain_i       (gain_q),
      .lft_i        (bus.proc_lft),
      .rht_i        (bus.proc_rht),
      .lft_o        (bus.lft_out),
      .rht_o        (bus.rht_out)
   );

   assign bus.intf_rst_n = (state_q != IDLE);
   assign bus.state      = state_q;
   assign bus.smp_strobe = strobe_q;
   assign bus.fault      = fault_q;
   assign bus.retry_cnt  = retry_q;

endmodule
`default_nettype wire
